// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the default counter width
// common to the PWM generator and pwm_capture.
package pwm_pkg;

    localparam int PWM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Input conditioning for pwm_capture: 2-flop synchroniser, optional 3-sample
// glitch filter (PWM_CAPTURE_FILTER_EN), level output and rise/fall pulses.
module pwm_sync_edge
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // The level only follows the synchroniser once it and its two previous
    // samples agree, so pulses shorter than 3 cycles never reach the FSM.
    logic r_hist1;
    logic r_hist2;
    logic r_hold;
    logic w_agree;

    assign w_agree = (r_sync2 == r_hist1) && (r_hist1 == r_hist2);
    assign w_s     = w_agree ? r_sync2 : r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist1 <= 1'b0;
            r_hist2 <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_hist1 <= r_sync2;
            r_hist2 <= r_hist1;
            r_hold  <= w_s;
        end
    end
`else
    assign w_s = r_sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign o_level = w_s;
    assign o_rise  = w_s & ~r_prev;
    assign o_fall  = ~w_s & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clock cycles.
// Optional input glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    pwm_state_e       r_state;
    pwm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] w_hcnt_nxt;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] w_pcnt_nxt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_pcnt_max;

    pwm_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pwm   (pwm_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_pcnt_max = (r_pcnt == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_hcnt    <= '0;
            r_pcnt    <= '0;
            r_duty    <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_duty    <= w_duty_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Timeout is checked before counting, so pcnt can never wrap; in LOW a
    // rising edge on the all-ones count still wins and latches period = max.
    always_comb begin
        w_state_nxt   = r_state;
        w_hcnt_nxt    = r_hcnt;
        w_pcnt_nxt    = r_pcnt;
        w_duty_nxt    = r_duty;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = r_timeout;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HIGH;
                        w_hcnt_nxt  = ONE;
                        w_pcnt_nxt  = ONE;
                    end
                end
                ST_HIGH: begin
                    if (w_pcnt_max) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b1;
                        w_hcnt_nxt    = '0;
                        w_pcnt_nxt    = '0;
                    end else if (w_fall) begin
                        w_state_nxt = ST_LOW;
                        w_pcnt_nxt  = r_pcnt + ONE;
                    end else begin
                        w_hcnt_nxt = r_hcnt + ONE;
                        w_pcnt_nxt = r_pcnt + ONE;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        w_state_nxt   = ST_HIGH;
                        w_duty_nxt    = r_hcnt;
                        w_period_nxt  = r_pcnt;
                        w_valid_nxt   = 1'b1;
                        w_timeout_nxt = 1'b0;
                        w_hcnt_nxt    = ONE;
                        w_pcnt_nxt    = ONE;
                    end else if (w_pcnt_max) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b1;
                        w_hcnt_nxt    = '0;
                        w_pcnt_nxt    = '0;
                    end else begin
                        w_pcnt_nxt = r_pcnt + ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hcnt_nxt  = '0;
                    w_pcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign duty    = r_duty;
    assign period  = r_period;
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign level   = w_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: random and directed PWM waveforms
// compared every cycle against a timestamp-based measurement model.
`timescale 1ns/1ps
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int W    = 8;
    localparam int MAXP = (1 << W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int SDLY  = 4;
    localparam int MINPH = 3;
`else
    localparam int SDLY  = 2;
    localparam int MINPH = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b1;
    logic         pwm_in = 1'b0;
    logic [W-1:0] duty;
    logic [W-1:0] period;
    logic         valid;
    logic         timeout;
    logic         level;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .pwm_in  (pwm_in),
        .duty    (duty),
        .period  (period),
        .valid   (valid),
        .timeout (timeout),
        .level   (level)
    );

    // Reference model: pwm_in seen through a fixed delay line, measurements
    // taken as differences of rise/fall timestamps.
    logic         sh [0:5];
    int           now = 0;
    int           lastRise = 0;
    int           lastFall = 0;
    bit           armed = 1'b0;
    logic         sNow;
    logic         sPrev;
    logic         mValid = 1'b0;
    logic         mTimeout = 1'b0;
    logic         mLevel = 1'b0;
    logic [W-1:0] mDuty = '0;
    logic [W-1:0] mPeriod = '0;

    initial begin
        for (int i = 0; i < 6; i++) sh[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                for (int i = 0; i < 6; i++) sh[i] = 1'b0;
                armed    = 1'b0;
                now      = 0;
                lastRise = 0;
                lastFall = 0;
                mValid   = 1'b0;
                mTimeout = 1'b0;
                mLevel   = 1'b0;
                mDuty    = '0;
                mPeriod  = '0;
            end else begin
                for (int i = 5; i > 0; i--) sh[i] = sh[i-1];
                sh[0]  = pwm_in;
                now++;
                sNow   = sh[SDLY];
                sPrev  = sh[SDLY+1];
                mLevel = sh[SDLY-1];
                mValid = 1'b0;
                if (enable !== 1'b1) begin
                    armed = 1'b0;
                end else if (sNow && !sPrev) begin
                    if (armed) begin
                        mValid   = 1'b1;
                        mDuty    = W'(lastFall - lastRise);
                        mPeriod  = W'(now - lastRise);
                        mTimeout = 1'b0;
                    end
                    armed    = 1'b1;
                    lastRise = now;
                end else if (armed && (now - lastRise == MAXP)) begin
                    mTimeout = 1'b1;
                    armed    = 1'b0;
                end else if (armed && !sNow && sPrev) begin
                    lastFall = now;
                end
            end
        end
    end

    // Waveform queue of {enable, pwm_in} per cycle.
    logic [1:0] wave[$];

    task automatic addPeriod(input int hi, input int lo, input logic en);
        for (int i = 0; i < hi; i++) wave.push_back({en, 1'b1});
        for (int i = 0; i < lo; i++) wave.push_back({en, 1'b0});
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (duty !== '0) begin failures++; $display("[TB] FAIL reset_duty: got %0d want 0", duty); end
        checks++;
        if (period !== '0) begin failures++; $display("[TB] FAIL reset_period: got %0d want 0", period); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
        checks++;
        if (level !== 1'b0) begin failures++; $display("[TB] FAIL reset_level: got %b want 0", level); end
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_steady();
        wave = {};
        for (int p = 0; p < 6; p++) addPeriod(3, 5, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL steady@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (duty !== 8'd3 || period !== 8'd8) begin
            failures++;
            $display("[TB] FAIL steady_3_8: got duty=%0d period=%0d want duty=3 period=8", duty, period);
        end
    endtask

    task automatic test_random();
        int hi;
        int lo;
        wave = {};
        for (int p = 0; p < 24; p++) begin
            hi = $urandom_range(40, MINPH);
            lo = ($urandom_range(9, 0) == 0) ? $urandom_range(270, 200) : $urandom_range(40, MINPH);
            addPeriod(hi, lo, 1'b1);
        end
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL random@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
    endtask

    task automatic test_loopback();
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(64, 192, 1'b1);
        for (int p = 0; p < 4; p++) addPeriod(64, 136, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL loopback@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            if (i == 3 * 256 - 1) begin
                checks++;
                if (timeout !== 1'b1) begin failures++; $display("[TB] FAIL loopback_256_timeout: got %b want 1", timeout); end
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (duty !== 8'd64 || period !== 8'd200 || timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL loopback_200: got duty=%0d period=%0d to=%b want duty=64 period=200 to=0", duty, period, timeout);
        end
    endtask

    task automatic test_timeout_high();
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(4, 4, 1'b1);
        addPeriod(300, 0, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL stuck_high@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (timeout !== 1'b1 || level !== 1'b1 || duty !== 8'd4 || period !== 8'd8) begin
            failures++;
            $display("[TB] FAIL stuck_high_state: got to=%b lvl=%b duty=%0d period=%0d want to=1 lvl=1 duty=4 period=8",
                     timeout, level, duty, period);
        end
        wave = {};
        addPeriod(0, 6, 1'b1);
        for (int p = 0; p < 3; p++) addPeriod(5, 4, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL recover@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (timeout !== 1'b0 || duty !== 8'd5 || period !== 8'd9) begin
            failures++;
            $display("[TB] FAIL recover_state: got to=%b duty=%0d period=%0d want to=0 duty=5 period=9", timeout, duty, period);
        end
    endtask

    task automatic test_edge_at_max();
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(10, 245, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL edge_max@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (period !== 8'd255 || duty !== 8'd10 || timeout !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_max_255: got duty=%0d period=%0d to=%b want duty=10 period=255 to=0", duty, period, timeout);
        end
        wave = {};
        for (int p = 0; p < 2; p++) addPeriod(10, 246, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL past_max@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (timeout !== 1'b1 || period !== 8'd255) begin
            failures++;
            $display("[TB] FAIL past_max_256: got to=%b period=%0d want to=1 period=255", timeout, period);
        end
    endtask

    task automatic test_reset_mid();
        int nValid;
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(5, 5, 1'b1);
        addPeriod(2, 0, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL pre_reset@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({duty, period, valid, timeout, level} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_clear: got duty=%0d period=%0d v=%b to=%b lvl=%b want all 0",
                     duty, period, valid, timeout, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nValid = 0;
        wave = {};
        for (int p = 0; p < 4; p++) addPeriod(5, 5, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL post_reset@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            if (valid === 1'b1) nValid++;
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (nValid != 3) begin
            failures++;
            $display("[TB] FAIL post_reset_valids: got %0d want 3", nValid);
        end
    endtask

    task automatic test_enable_low();
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(5, 5, 1'b1);
        for (int p = 0; p < 2; p++) addPeriod(6, 6, 1'b0);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL enable_low@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (duty !== 8'd5 || period !== 8'd10 || valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL enable_low_hold: got duty=%0d period=%0d v=%b want duty=5 period=10 v=0", duty, period, valid);
        end
        wave = {};
        for (int p = 0; p < 3; p++) addPeriod(6, 6, 1'b1);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            checks++;
            if ({valid, timeout, level, duty, period} !== {mValid, mTimeout, mLevel, mDuty, mPeriod}) begin
                failures++;
                $display("[TB] FAIL reenable@%0d: got v=%b to=%b lvl=%b duty=%0d period=%0d want v=%b to=%b lvl=%b duty=%0d period=%0d",
                         i, valid, timeout, level, duty, period, mValid, mTimeout, mLevel, mDuty, mPeriod);
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (duty !== 8'd6 || period !== 8'd12) begin
            failures++;
            $display("[TB] FAIL reenable_6_12: got duty=%0d period=%0d want duty=6 period=12", duty, period);
        end
    endtask

`ifdef PWM_CAPTURE_FILTER_EN
    task automatic test_glitch();
        int nValid;
        wave = {};
        addPeriod(0, 4, 1'b0);
        for (int p = 0; p < 2; p++) addPeriod(6, 10, 1'b1);
        addPeriod(6, 4, 1'b1);
        addPeriod(0, 1, 1'b1);
        wave[$] = 2'b11;
        addPeriod(0, 5, 1'b1);
        addPeriod(6, 3, 1'b1);
        addPeriod(2, 5, 1'b1);
        for (int p = 0; p < 2; p++) addPeriod(6, 10, 1'b1);
        nValid = 0;
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                nValid++;
                checks++;
                if (duty !== 8'd6 || period !== 8'd16) begin
                    failures++;
                    $display("[TB] FAIL glitch_meas@%0d: got duty=%0d period=%0d want duty=6 period=16", i, duty, period);
                end
            end
            {enable, pwm_in} = wave[i];
        end
        checks++;
        if (nValid != 5) begin
            failures++;
            $display("[TB] FAIL glitch_valids: got %0d want 5", nValid);
        end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_steady();
        test_random();
        test_loopback();
        test_timeout_high();
        test_edge_at_max();
        test_reset_mid();
        test_enable_low();
`ifdef PWM_CAPTURE_FILTER_EN
        test_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart of the team's PWM generator: it sits on a dedicated input pin and feeds the measured values to downstream logic or to the output pins. The input is asynchronous to the block clock and is synchronised internally. Each complete period produces one registered measurement with a single-cycle valid strobe.

## Interface
- `WIDTH`, default 8: counter and result width; the longest measurable period is 2^WIDTH-1 cycles.
- `clk` input 1: block clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: when low, the block returns to IDLE, counters clear and results hold.
- `pwm_in` input 1: asynchronous PWM input.
- `duty` output WIDTH: high-time in cycles of the last complete period.
- `period` output WIDTH: rising-edge-to-rising-edge cycle count of the last complete period.
- `valid` output 1: one-cycle strobe when `duty`/`period` update.
- `timeout` output 1: sticky; no rising edge seen within 2^WIDTH-1 cycles.
- `level` output 1: current synchronised (and filtered) input level.

## Operation
- Input path: 2-flop synchroniser, giving signal `s`, then an edge detector comparing `s` with its previous value.
- States:
  - IDLE: wait for the first rising edge. On it, load `hcnt`=1 and `pcnt`=1, go to HIGH, no `valid`.
  - HIGH: `pcnt`++ and `hcnt`++ each cycle. A falling edge moves to LOW; `pcnt` still increments and `hcnt` does not.
  - LOW: `pcnt`++ each cycle. A rising edge latches `duty`<=`hcnt` and `period`<=`pcnt`, pulses `valid`, clears `timeout`, reloads both counters to 1 and returns to HIGH.
- Timeout: in HIGH or LOW, when `pcnt` equals all-ones and no rising edge occurs that cycle:
  - go to IDLE and set `timeout`.
  - `duty` and `period` hold.
  - `level` tells the consumer whether the input is stuck at 0% or 100%.
- Simultaneous events: a rising edge in the same cycle that `pcnt` is all-ones wins. The block latches `period`=2^WIDTH-1 and no timeout fires.
- Arithmetic: counters are unsigned WIDTH bits and never wrap, because timeout precedes overflow. `duty` < `period` always holds for a valid measurement.
- `enable` low: synchronous return to IDLE, counters 0, `valid`=0. `duty`, `period` and `timeout` hold. The synchroniser keeps running.
- Reset mid-measurement: everything clears asynchronously. After reset the first measurement needs two rising edges.

## Timing
- Reset values: `duty`=0, `period`=0, `valid`=0, `timeout`=0, `level`=0, state IDLE, synchroniser flops 0.
- `pwm_in` to `s`: 2 cycles.
- `valid` is registered and asserts the cycle after the detecting rising edge of `s`, so it comes 3 cycles after the `pwm_in` rising edge.
- `valid` is never high on two consecutive cycles. Minimum spacing is 2 cycles (a period of 2).
- `timeout` rises the cycle after the all-ones count is reached with no edge.
- Minimum resolvable high or low phase: 1 cycle without the filter, 3 cycles with it.

## Configuration
- `PWM_CAPTURE_FILTER_EN` defined: a 3-sample agreement glitch filter follows the synchroniser.
  - `s` changes only after 3 consecutive equal samples.
  - This adds 2 cycles of latency to every edge, so `valid` comes 5 cycles after a `pwm_in` edge.
  - Pulses shorter than 3 cycles are rejected.
- Undefined: no filter, and the latencies above apply.

## Structure
- Shared package `pwm_pkg`:
  - state enum (IDLE, HIGH, LOW)
  - default `WIDTH` constant, shared with the PWM generator
- Sub-module `pwm_sync_edge`: synchroniser, optional filter, `level`, and rise/fall pulses.
- The FSM and counters live in `pwm_capture`.

## Test plan
- Steady waveform, 3 high / 5 low, WIDTH=8 → after the second rising edge, `valid` pulses every 8 cycles with `duty`=3, `period`=8.
- Loopback from the PWM generator with duty 64, max 255 → `duty`=64, `period`=256 saturates at timeout. Also run max 199 → `period`=200, `duty`=64.
- Input held high after one edge → `timeout`=1 about 255 cycles later, `level`=1, `duty`/`period` unchanged. The next two edges clear `timeout` and restore `valid`.
- Rising edge exactly on the all-ones count → `period`=255, `timeout` stays 0.
- `rst_n` pulsed low mid-period → all outputs 0 immediately, and the first `valid` arrives only after two further rising edges. Repeat with `enable` deasserted: outputs hold, `valid` is suppressed.
- With `PWM_CAPTURE_FILTER_EN`: a 1-cycle glitch inside the low phase → measurement unchanged. A 2-cycle glitch → also rejected.
